// File: rtl/xt_hb_system_timer_pkg.sv
// xt_hb_system_timer_pkg: HB bus select strobes, system-timer word offsets and
// the word-decode helper shared by the timer and its decoder.
package xt_hb_system_timer_pkg;
   typedef struct packed {
      logic ren;
      logic wen;
   } sel_t;
   localparam logic [1:0] SYSTIMER_MTIME_LO    = 2'd0;
   localparam logic [1:0] SYSTIMER_MTIME_HI    = 2'd1;
   localparam logic [1:0] SYSTIMER_MTIMECMP_LO = 2'd2;
   localparam logic [1:0] SYSTIMER_MTIMECMP_HI = 2'd3;
   // {hit, word}: hit only for the four aligned offsets base+0/4/8/12
   function automatic logic [2:0] word_dec(input logic [7:0] addr, input logic [7:0] base);
      logic [7:0] d;
      d = addr - base;
      return {addr >= base && d[7:4] == 4'd0 && d[1:0] == 2'd0, d[3:2]};
   endfunction
endpackage

// File: rtl/xt_hb_system_timer_if.sv
// xt_hb_system_timer_if: HB decoder-to-slave strobes, addresses and data.
interface xt_hb_system_timer_if;
   import xt_hb_system_timer_pkg::*;
   sel_t        hb_sel;
   logic [7:0]  hb_raddr;
   logic [7:0]  hb_waddr;
   logic [31:0] hb_wdata;
   logic [31:0] hb_rdata;
   modport master(output hb_sel, hb_raddr, hb_waddr, hb_wdata, input hb_rdata);
   modport slave(input hb_sel, hb_raddr, hb_waddr, hb_wdata, output hb_rdata);
endinterface

// File: rtl/xt_hb_system_timer_divider.sv
// xt_tick_divider: prescaler; tick on the last count of each DIV-cycle period.
module xt_tick_divider #(
   parameter int DIV = 1
) (
   input  logic hb_clk,
   input  logic rst,
   output logic tick
);
   logic [15:0] r_cnt;
   assign tick = r_cnt == 16'(DIV - 1);
   always_ff @(posedge hb_clk or posedge rst)
      if (rst) r_cnt <= '0;
      else r_cnt <= tick ? '0 : r_cnt + 16'd1;
endmodule

// File: rtl/xt_hb_system_timer.sv
// xt_hb_system_timer: 64-bit mtime/mtimecmp responder on the HB bus with
// coherent high-word shadow and registered machine-timer interrupt.
module xt_hb_system_timer
   import xt_hb_system_timer_pkg::*;
#(
   parameter logic [7:0] BASE_ADDR    = 8'd12,
   parameter int         PRESCALE_DIV = 1
) (
   input  logic                   hb_clk,
   input  logic                   rst,
   xt_hb_system_timer_if.slave    hb,
   output logic                   timer_irq
);
   logic        w_tick;
   logic [2:0]  w_rdec;
   logic [2:0]  w_wdec;
   logic        w_wr_lo;
   logic        w_wr_hi;
   logic        w_wr_clo;
   logic        w_wr_chi;
   logic [31:0] w_rword;
   logic [31:0] r_lo;
   logic [31:0] r_hi;
   logic [31:0] r_cmp_lo;
   logic [31:0] r_cmp_hi;
   logic [31:0] r_shadow;
   logic [31:0] r_rdata;
   logic        r_irq;

   xt_tick_divider #(.DIV(PRESCALE_DIV)) u_div (
      .hb_clk (hb_clk),
      .rst    (rst),
      .tick   (w_tick)
   );

   assign w_rdec   = word_dec(hb.hb_raddr, BASE_ADDR);
   assign w_wdec   = word_dec(hb.hb_waddr, BASE_ADDR);
   assign w_wr_lo  = hb.hb_sel.wen && w_wdec == {1'b1, SYSTIMER_MTIME_LO};
   assign w_wr_hi  = hb.hb_sel.wen && w_wdec == {1'b1, SYSTIMER_MTIME_HI};
   assign w_wr_clo = hb.hb_sel.wen && w_wdec == {1'b1, SYSTIMER_MTIMECMP_LO};
   assign w_wr_chi = hb.hb_sel.wen && w_wdec == {1'b1, SYSTIMER_MTIMECMP_HI};
   assign hb.hb_rdata = r_rdata;
   assign timer_irq   = r_irq;

   // HI reads come from the shadow so a LO-then-HI pair is one coherent sample
   always_comb
      w_rword = !w_rdec[2]                           ? 32'd0    :
                w_rdec[1:0] == SYSTIMER_MTIME_LO     ? r_lo     :
                w_rdec[1:0] == SYSTIMER_MTIME_HI     ? r_shadow :
                w_rdec[1:0] == SYSTIMER_MTIMECMP_LO  ? r_cmp_lo : r_cmp_hi;

   // A write owns its half; a LO write also blocks the carry into HI
   always_ff @(posedge hb_clk or posedge rst)
      if (rst) begin
         r_lo     <= '0;
         r_hi     <= '0;
         r_cmp_lo <= '1;
         r_cmp_hi <= '1;
         r_shadow <= '0;
         r_rdata  <= '0;
         r_irq    <= 1'b0;
      end else begin
         r_lo  <= w_wr_lo ? hb.hb_wdata : r_lo + 32'(w_tick);
         r_hi  <= w_wr_hi ? hb.hb_wdata : (!w_wr_lo && w_tick && &r_lo) ? r_hi + 32'd1 : r_hi;
         r_irq <= {r_hi, r_lo} >= {r_cmp_hi, r_cmp_lo};
         if (w_wr_clo) r_cmp_lo <= hb.hb_wdata;
         if (w_wr_chi) r_cmp_hi <= hb.hb_wdata;
         if (hb.hb_sel.ren) r_rdata <= w_rword;
         if (hb.hb_sel.ren && w_rdec == {1'b1, SYSTIMER_MTIME_LO}) r_shadow <= r_hi;
      end
endmodule
